// File: rtl/wave_pkg.sv
// wave_pkg: shared definitions for the waveform segment sequencer.
//   - default widths for the rate/delay value, the segment duration and the
//     segment table depth
//   - sequencer FSM state encoding
//   - segment record layout (rate, gain, dur, last) at the default widths
package wave_pkg;

   localparam int COUNT_DEF = 16;
   localparam int DUR_W_DEF = 16;
   localparam int NSEG_DEF  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic [COUNT_DEF-1:0] rate;
      logic [1:0]           gain;
      logic [DUR_W_DEF-1:0] dur;
      logic                 last;
   } seg_t;

endpackage

// File: rtl/wave_seg_table.sv
// wave_seg_table: NSEG-entry segment table.
//   Synchronous write port (i_we/i_waddr/i_w*), asynchronous read port
//   (i_raddr -> o_r*). Asynchronous active-high reset clears every entry.
//   i_clk, i_rst          : clock, async reset
//   i_we, i_waddr, i_w*   : write strobe, entry index, entry fields
//   i_raddr, o_r*         : read index, entry fields of that index
module wave_seg_table
   import wave_pkg::*;
#(
   parameter int COUNT = COUNT_DEF,
   parameter int DUR_W = DUR_W_DEF,
   parameter int NSEG  = NSEG_DEF
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_we,
   input  logic [$clog2(NSEG)-1:0] i_waddr,
   input  logic [COUNT-1:0]        i_wrate,
   input  logic [1:0]              i_wgain,
   input  logic [DUR_W-1:0]        i_wdur,
   input  logic                    i_wlast,
   input  logic [$clog2(NSEG)-1:0] i_raddr,
   output logic [COUNT-1:0]        o_rrate,
   output logic [1:0]              o_rgain,
   output logic [DUR_W-1:0]        o_rdur,
   output logic                    o_rlast
);

   logic [COUNT-1:0] rate_q [NSEG];
   logic [1:0]       gain_q [NSEG];
   logic [DUR_W-1:0] dur_q  [NSEG];
   logic             last_q [NSEG];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < NSEG; i++) begin
            rate_q[i] <= '0;
            gain_q[i] <= '0;
            dur_q[i]  <= '0;
            last_q[i] <= 1'b0;
         end
      end else if (i_we) begin
         rate_q[i_waddr] <= i_wrate;
         gain_q[i_waddr] <= i_wgain;
         dur_q[i_waddr]  <= i_wdur;
         last_q[i_waddr] <= i_wlast;
      end
   end

   assign o_rrate = rate_q[i_raddr];
   assign o_rgain = gain_q[i_raddr];
   assign o_rdur  = dur_q[i_raddr];
   assign o_rlast = last_q[i_raddr];

endmodule

// File: rtl/wave_seq_ctrl.sv
// wave_seq_ctrl: steps a waveform generator through a table of segments.
//   Each segment is one LOAD cycle (rate/gain registered onto the generator
//   controls) followed by max(dur,1) RUN cycles with the generator enabled.
//   Ports:
//   i_clk, i_rst                        : clock, async active-high reset
//   i_cfg_we/addr/rate/gain/dur/last    : segment table write (idle only)
//   i_start, i_abort, i_loop            : sequence control
//   o_count_delay, o_sel_gain, o_gen_en : generator controls
//   o_seg_idx, o_busy, o_done           : sequence status
//   o_cfg_err                           : pulse when a write was dropped
module wave_seq_ctrl
   import wave_pkg::*;
#(
   parameter int COUNT = COUNT_DEF,
   parameter int DUR_W = DUR_W_DEF,
   parameter int NSEG  = NSEG_DEF
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_cfg_we,
   input  logic [$clog2(NSEG)-1:0] i_cfg_addr,
   input  logic [COUNT-1:0]        i_cfg_rate,
   input  logic [1:0]              i_cfg_gain,
   input  logic [DUR_W-1:0]        i_cfg_dur,
   input  logic                    i_cfg_last,
   input  logic                    i_start,
   input  logic                    i_abort,
   input  logic                    i_loop,
   output logic [COUNT-1:0]        o_count_delay,
   output logic [1:0]              o_sel_gain,
   output logic                    o_gen_en,
   output logic [$clog2(NSEG)-1:0] o_seg_idx,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_cfg_err
);

   localparam int AW = $clog2(NSEG);
   localparam logic [AW-1:0] IDX_LAST = AW'(NSEG - 1);

   state_t           state_q;
   logic [AW-1:0]    idx_q;
   logic [DUR_W-1:0] dur_cnt_q;
   logic [COUNT-1:0] count_delay_q;
   logic [1:0]       sel_gain_q;
   logic             cfg_err_q;
   logic             busy;

   logic [COUNT-1:0] rd_rate;
   logic [1:0]       rd_gain;
   logic [DUR_W-1:0] rd_dur;
   logic             rd_last;

   assign busy = (state_q != ST_IDLE);

   // Writes are only accepted while idle so a running sequence never sees
   // its table change underneath it.
   wave_seg_table #(
      .COUNT (COUNT),
      .DUR_W (DUR_W),
      .NSEG  (NSEG)
   ) u_table (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (i_cfg_we && !busy),
      .i_waddr (i_cfg_addr),
      .i_wrate (i_cfg_rate),
      .i_wgain (i_cfg_gain),
      .i_wdur  (i_cfg_dur),
      .i_wlast (i_cfg_last),
      .i_raddr (idx_q),
      .o_rrate (rd_rate),
      .o_rgain (rd_gain),
      .o_rdur  (rd_dur),
      .o_rlast (rd_last)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         dur_cnt_q     <= '0;
         count_delay_q <= '0;
         sel_gain_q    <= '0;
         cfg_err_q     <= 1'b0;
      end else begin
         cfg_err_q <= i_cfg_we && busy;
         case (state_q)
            ST_IDLE: begin
               if (i_start && !i_abort) begin
                  state_q <= ST_LOAD;
                  idx_q   <= '0;
               end
            end
            ST_LOAD: begin
               if (i_abort) begin
                  state_q <= ST_IDLE;
               end else begin
                  count_delay_q <= rd_rate;
                  sel_gain_q    <= rd_gain;
                  // A zero duration still gives one enabled cycle.
                  dur_cnt_q     <= (rd_dur == '0) ? DUR_W'(1) : rd_dur;
                  state_q       <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (i_abort) begin
                  state_q <= ST_IDLE;
               end else begin
                  dur_cnt_q <= dur_cnt_q - DUR_W'(1);
                  if (dur_cnt_q == DUR_W'(1)) begin
                     // End of segment: advance, wrap on loop, or finish.
                     if (!rd_last && (idx_q != IDX_LAST)) begin
                        idx_q   <= idx_q + AW'(1);
                        state_q <= ST_LOAD;
                     end else if (i_loop) begin
                        idx_q   <= '0;
                        state_q <= ST_LOAD;
                     end else begin
                        state_q <= ST_DONE;
                     end
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_count_delay = count_delay_q;
   assign o_sel_gain    = sel_gain_q;
   assign o_gen_en      = (state_q == ST_RUN);
   assign o_seg_idx     = idx_q;
   assign o_busy        = busy;
   assign o_done        = (state_q == ST_DONE);
   assign o_cfg_err     = cfg_err_q;

endmodule

// File: doc/wave_seq_ctrl.md
WAVE_SEQ_CTRL -- requirements
Module: wave_seq_ctrl

Interface
REQ-001 SHALL have parameter COUNT, default 16: width of the generator rate/delay value.
REQ-002 SHALL have parameter DUR_W, default 16: width of the segment duration.
REQ-003 SHALL have parameter NSEG, default 4: number of segment table entries, a power of two and at least 2.
REQ-004 SHALL have port i_clk, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port i_rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port i_cfg_we, input, 1: segment table write strobe.
REQ-007 SHALL have port i_cfg_addr, input, log2(NSEG): table entry index.
REQ-008 SHALL have port i_cfg_rate, input, COUNT: tick delay for the entry.
REQ-009 SHALL have port i_cfg_gain, input, 2: gain select for the entry.
REQ-010 SHALL have port i_cfg_dur, input, DUR_W: segment length in cycles.
REQ-011 SHALL have port i_cfg_last, input, 1: marks the entry as the final segment.
REQ-012 SHALL have port i_start, input, 1: single-cycle sequence start.
REQ-013 SHALL have port i_abort, input, 1: stop immediately.
REQ-014 SHALL have port i_loop, input, 1: restart at segment 0 after the last segment; this is a level, sampled at the end of the last segment.
REQ-015 SHALL have port o_count_delay, output, COUNT: drives the generator delay input.
REQ-016 SHALL have port o_sel_gain, output, 2: drives the generator gain select.
REQ-017 SHALL have port o_gen_en, output, 1: generator run gate.
REQ-018 SHALL have port o_seg_idx, output, log2(NSEG): current segment.
REQ-019 SHALL have port o_busy, output, 1: high when not IDLE.
REQ-020 SHALL have port o_done, output, 1: one-cycle pulse when a sequence completes.
REQ-021 SHALL have port o_cfg_err, output, 1: one-cycle pulse when a table write is rejected.

Function
REQ-022 SHALL implement FSM states IDLE, LOAD, RUN and DONE.
REQ-023 In IDLE, i_start=1 with i_abort=0 SHALL go to LOAD with segment index 0.
REQ-024 In IDLE, i_start and i_abort both high SHALL leave the FSM in IDLE; abort wins.
REQ-025 LOAD SHALL last one cycle: register the entry's rate into o_count_delay and its gain into o_sel_gain, load the duration counter with max(dur,1), then go to RUN.
REQ-026 RUN SHALL assert o_gen_en (decoded from the registered state) and decrement the duration counter each cycle, so RUN lasts exactly max(dur,1) cycles.
REQ-027 At the end of RUN, if the entry is not last and the index is below NSEG-1, the FSM SHALL go to LOAD with index+1.
REQ-028 At the end of RUN, if the entry is last or the index equals NSEG-1 (end of table), the FSM SHALL go to LOAD with index 0 when i_loop=1, otherwise to DONE.
REQ-029 DONE SHALL last one cycle, assert o_done for that cycle, then go to IDLE.
REQ-030 i_abort in LOAD, RUN or DONE SHALL force IDLE on the next edge; an abort in DONE still completes that cycle's o_done pulse, and an abort in LOAD or RUN produces no o_done.
REQ-031 i_start while o_busy=1 SHALL be ignored.
REQ-032 o_count_delay and o_sel_gain SHALL hold their last loaded values outside LOAD, including in IDLE after a sequence ends.
REQ-033 A table write when o_busy=0 SHALL update the entry at the next edge.
REQ-034 A table write when o_busy=1 SHALL be discarded, with o_cfg_err pulsed for one cycle on the next cycle.
REQ-035 Latency: i_start sampled at edge k gives o_busy=1 after edge k and o_gen_en=1 after edge k+1.
REQ-036 No segment gap: the next segment's o_gen_en low time SHALL be exactly the one LOAD cycle.

Reset
REQ-037 i_rst SHALL asynchronously force IDLE, index 0 and duration counter 0.
REQ-038 Reset SHALL drive o_count_delay=0, o_sel_gain=0, o_gen_en=0, o_seg_idx=0, o_busy=0, o_done=0 and o_cfg_err=0.
REQ-039 Reset SHALL clear all table entries to rate 0, gain 0, dur 0 and last 0.
REQ-040 Reset asserted mid-sequence SHALL produce no o_done.

Structure
REQ-041 Package wave_pkg SHALL hold the FSM state enum, the segment struct (rate, gain, dur, last) and the default widths.
REQ-042 The table SHALL be a sub-module wave_seg_table: NSEG registers with a write port and an asynchronous read port.
REQ-043 The FSM, duration counter and output registers SHALL live in wave_seq_ctrl.

Verification
REQ-044 Basic sequence: table {0:(rate 5,gain 1,dur 3,last 0), 1:(rate 9,gain 2,dur 2,last 1)}, start -> o_gen_en high 3 cycles with delay 5/gain 1, low 1 cycle, high 2 cycles with delay 9/gain 2, then o_done one cycle, then o_busy=0.
REQ-045 Loop: same table with i_loop=1 -> segment 0 reloads after segment 1; clearing i_loop lets the sequence finish with o_done after the next segment 1.
REQ-046 Abort: abort in the 2nd RUN cycle of segment 0 -> IDLE next cycle, o_gen_en=0, no o_done, outputs hold delay 5.
REQ-047 Edge values: dur=0 entry -> exactly 1 RUN cycle; table with no last flag -> runs all NSEG entries then DONE; start and abort in the same cycle -> stays IDLE.
REQ-048 Config while busy: write during RUN -> o_cfg_err pulse and entry unchanged on the next run; restart while busy is ignored.
REQ-049 Reset mid-RUN: all outputs go to 0 immediately (asynchronously), and the table reads all zero.
